// File: rtl/mem_port_arbiter_if.sv
// Signal bundle shared by mem_port_arbiter, its fetch/data requesters and the memory port.
// slave is the arbiter's view; master is the requester/memory environment's view.
interface mem_port_arbiter_if;

   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic        d_err;
   logic [31:0] d_rdata;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  i_req, i_addr,
      output i_ack, i_rdata,
      input  d_req, d_we, d_size, d_addr, d_wdata,
      output d_ack, d_err, d_rdata,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport master (
      output i_req, i_addr,
      input  i_ack, i_rdata,
      output d_req, d_we, d_size, d_addr, d_wdata,
      input  d_ack, d_err, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ready
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and load/store: grant, byte enables, misalign reject.
// Build macro ARB_FAIRNESS_EN: fetch wins after STARVE_LIMIT data grants made while fetch waited.
module mem_port_arbiter
`ifdef ARB_FAIRNESS_EN
#(
   parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave io_bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BUSY_I,
      ST_BUSY_D,
      ST_DONE_I,
      ST_DONE_D
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        w_grant_i;
   logic        w_grant_d;
   logic        w_mem_req;
   logic        w_i_ack;
   logic        w_d_ack;
   logic        w_d_misaligned;
   logic        w_fetch_priority;
   logic [3:0]  w_d_be;

   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic        r_d_err;
   logic [31:0] r_i_rdata;
   logic [31:0] r_d_rdata;

   // Alignment check and lane enables for the data request as presented.
   always_comb begin
      w_d_misaligned = 1'b0;
      w_d_be         = 4'b0000;
      case (io_bus.d_size)
         2'b00: w_d_be = 4'b0001 << io_bus.d_addr[1:0];
         2'b01: begin
            w_d_be         = io_bus.d_addr[1] ? 4'b1100 : 4'b0011;
            w_d_misaligned = io_bus.d_addr[0];
         end
         2'b10: begin
            w_d_be         = 4'b1111;
            w_d_misaligned = (io_bus.d_addr[1:0] != 2'b00);
         end
         default: w_d_misaligned = 1'b1;
      endcase
   end

`ifdef ARB_FAIRNESS_EN
   logic [3:0] r_starve_cnt;

   assign w_fetch_priority = (r_starve_cnt == 4'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= 4'd0;
      end else if (w_grant_i) begin
         r_starve_cnt <= 4'd0;
      end else if (r_state == ST_IDLE && !io_bus.i_req) begin
         r_starve_cnt <= 4'd0;
      end else if (w_grant_d && io_bus.i_req) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end
`else
   assign w_fetch_priority = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
      w_state_next = r_state;
      w_grant_i    = 1'b0;
      w_grant_d    = 1'b0;
      w_mem_req    = 1'b0;
      w_i_ack      = 1'b0;
      w_d_ack      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.d_req && !(io_bus.i_req && w_fetch_priority)) begin
               w_grant_d    = 1'b1;
               w_state_next = w_d_misaligned ? ST_DONE_D : ST_BUSY_D;
            end else if (io_bus.i_req) begin
               w_grant_i    = 1'b1;
               w_state_next = ST_BUSY_I;
            end
         end
         ST_BUSY_I: begin
            w_mem_req = 1'b1;
            if (io_bus.mem_ready) w_state_next = ST_DONE_I;
         end
         ST_BUSY_D: begin
            w_mem_req = 1'b1;
            if (io_bus.mem_ready) w_state_next = ST_DONE_D;
         end
         ST_DONE_I: begin
            w_i_ack      = 1'b1;
            w_state_next = ST_IDLE;
         end
         ST_DONE_D: begin
            w_d_ack      = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Bus fields are loaded only at grant and held through BUSY; rejected requests never touch them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= 32'd0;
      end else if (w_grant_i) begin
         r_mem_we   <= 1'b0;
         r_mem_addr <= io_bus.i_addr & 32'hFFFF_FFFC;
         r_mem_be   <= 4'b1111;
      end else if (w_grant_d && !w_d_misaligned) begin
         r_mem_we    <= io_bus.d_we;
         r_mem_addr  <= io_bus.d_addr;
         r_mem_be    <= w_d_be;
         r_mem_wdata <= io_bus.d_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_err <= 1'b0;
      end else if (w_grant_d) begin
         r_d_err <= w_d_misaligned;
      end
   end

   // Read data persists between acks; a completing store leaves the load data alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i_rdata <= 32'd0;
         r_d_rdata <= 32'd0;
      end else if (io_bus.mem_ready) begin
         if (r_state == ST_BUSY_I) r_i_rdata <= io_bus.mem_rdata;
         if (r_state == ST_BUSY_D && !r_mem_we) r_d_rdata <= io_bus.mem_rdata;
      end
   end

   assign io_bus.mem_req   = w_mem_req;
   assign io_bus.mem_we    = r_mem_we;
   assign io_bus.mem_addr  = r_mem_addr;
   assign io_bus.mem_be    = r_mem_be;
   assign io_bus.mem_wdata = r_mem_wdata;
   assign io_bus.i_ack     = w_i_ack;
   assign io_bus.i_rdata   = r_i_rdata;
   assign io_bus.d_ack     = w_d_ack;
   assign io_bus.d_err     = w_d_ack & r_d_err;
   assign io_bus.d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table-driven data vectors plus fetch, contention,
// wait-state and mid-access reset sequences. Expected grant order follows ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      logic        exp_err;
      logic [3:0]  exp_be;
   } dvec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   logic [31:0] exp_d_rdata;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one cycle; drive and sample on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic dvec_t mk(input string n, input logic we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mrdata, input logic exp_err,
                                input logic [3:0] exp_be);
      dvec_t v;
      v.name = n; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
      v.mrdata = mrdata; v.exp_err = exp_err; v.exp_be = exp_be;
      return v;
   endfunction

   task automatic run_data(input dvec_t v);
      bus.d_req     = 1'b1;
      bus.d_we      = v.we;
      bus.d_size    = v.size;
      bus.d_addr    = v.addr;
      bus.d_wdata   = v.wdata;
      bus.mem_rdata = v.mrdata;
      bus.mem_ready = 1'b1;
      tick();
      if (v.exp_err) begin
         check({v.name, "/c1_d_ack"}, 32'(bus.d_ack), 32'd1);
         check({v.name, "/c1_d_err"}, 32'(bus.d_err), 32'd1);
         check({v.name, "/c1_mem_req"}, 32'(bus.mem_req), 32'd0);
         bus.d_req = 1'b0;
         tick();
         check({v.name, "/c2_mem_req"}, 32'(bus.mem_req), 32'd0);
         check({v.name, "/c2_d_ack"}, 32'(bus.d_ack), 32'd0);
      end else begin
         check({v.name, "/c1_mem_req"}, 32'(bus.mem_req), 32'd1);
         check({v.name, "/c1_mem_addr"}, bus.mem_addr, v.addr);
         check({v.name, "/c1_mem_be"}, 32'(bus.mem_be), 32'(v.exp_be));
         check({v.name, "/c1_mem_we"}, 32'(bus.mem_we), 32'(v.we));
         check({v.name, "/c1_d_ack"}, 32'(bus.d_ack), 32'd0);
         if (v.we) check({v.name, "/c1_mem_wdata"}, bus.mem_wdata, v.wdata);
         tick();
         if (!v.we) exp_d_rdata = v.mrdata;
         check({v.name, "/c2_d_ack"}, 32'(bus.d_ack), 32'd1);
         check({v.name, "/c2_d_err"}, 32'(bus.d_err), 32'd0);
         check({v.name, "/c2_mem_req"}, 32'(bus.mem_req), 32'd0);
         check({v.name, "/c2_d_rdata"}, bus.d_rdata, exp_d_rdata);
         bus.d_req = 1'b0;
         tick();
         check({v.name, "/c3_d_ack"}, 32'(bus.d_ack), 32'd0);
         check({v.name, "/c3_mem_req"}, 32'(bus.mem_req), 32'd0);
      end
   endtask

   initial begin
      dvec_t vecs[9];
      logic [9:0] exp_fetch;
      int n_seen;
      int last_cyc;
      int busy;

      n_cmp       = 0;
      n_fail      = 0;
      exp_d_rdata = 32'd0;

      vecs[0] = mk("ld_b_206",   1'b0, 2'b00, 32'h0000_0206, 32'h0,          32'h1122_3344, 1'b0, 4'b0100);
      vecs[1] = mk("ld_h_202",   1'b0, 2'b01, 32'h0000_0202, 32'h0,          32'hAABB_CCDD, 1'b0, 4'b1100);
      vecs[2] = mk("st_w_208",   1'b1, 2'b10, 32'h0000_0208, 32'hDEAD_BEEF, 32'h9999_9999, 1'b0, 4'b1111);
      vecs[3] = mk("ld_b_203",   1'b0, 2'b00, 32'h0000_0203, 32'h0,          32'h5566_7788, 1'b0, 4'b1000);
      vecs[4] = mk("ld_h_200",   1'b0, 2'b01, 32'h0000_0200, 32'h0,          32'h0102_0304, 1'b0, 4'b0011);
      vecs[5] = mk("mis_w_101",  1'b0, 2'b10, 32'h0000_0101, 32'h0,          32'h4444_4444, 1'b1, 4'b0000);
      vecs[6] = mk("mis_h_003",  1'b0, 2'b01, 32'h0000_0003, 32'h0,          32'h4444_4444, 1'b1, 4'b0000);
      vecs[7] = mk("mis_sz11",   1'b1, 2'b11, 32'h0000_0000, 32'h1234_5678, 32'h4444_4444, 1'b1, 4'b0000);
      vecs[8] = mk("ld_w_400",   1'b0, 2'b10, 32'h0000_0400, 32'h0,          32'hCAFE_F00D, 1'b0, 4'b1111);

      rst_n         = 1'b1;
      bus.i_req     = 1'b0;
      bus.i_addr    = 32'd0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_size    = 2'b00;
      bus.d_addr    = 32'd0;
      bus.d_wdata   = 32'd0;
      bus.mem_rdata = 32'd0;
      bus.mem_ready = 1'b1;

      // Reset values
      #3 rst_n = 1'b0;
      #1;
      check("rst/mem_req",   32'(bus.mem_req), 32'd0);
      check("rst/mem_we",    32'(bus.mem_we), 32'd0);
      check("rst/mem_addr",  bus.mem_addr, 32'd0);
      check("rst/mem_be",    32'(bus.mem_be), 32'd0);
      check("rst/mem_wdata", bus.mem_wdata, 32'd0);
      check("rst/i_ack",     32'(bus.i_ack), 32'd0);
      check("rst/d_ack",     32'(bus.d_ack), 32'd0);
      check("rst/d_err",     32'(bus.d_err), 32'd0);
      check("rst/i_rdata",   bus.i_rdata, 32'd0);
      check("rst/d_rdata",   bus.d_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Fetch only, low address bits dropped
      bus.i_req     = 1'b1;
      bus.i_addr    = 32'h0000_1003;
      bus.mem_rdata = 32'hE3A0_0001;
      tick();
      check("fetch/c1_mem_req",  32'(bus.mem_req), 32'd1);
      check("fetch/c1_mem_addr", bus.mem_addr, 32'h0000_1000);
      check("fetch/c1_mem_be",   32'(bus.mem_be), 32'hF);
      check("fetch/c1_mem_we",   32'(bus.mem_we), 32'd0);
      check("fetch/c1_i_ack",    32'(bus.i_ack), 32'd0);
      tick();
      check("fetch/c2_i_ack",    32'(bus.i_ack), 32'd1);
      check("fetch/c2_i_rdata",  bus.i_rdata, 32'hE3A0_0001);
      check("fetch/c2_mem_req",  32'(bus.mem_req), 32'd0);
      bus.i_req = 1'b0;
      tick();
      check("fetch/c3_i_ack",    32'(bus.i_ack), 32'd0);
      check("fetch/c3_mem_req",  32'(bus.mem_req), 32'd0);

      // Table-driven data accesses
      for (int k = 0; k < 9; k++) run_data(vecs[k]);

      // Contention: both requesters held high throughout
`ifdef ARB_FAIRNESS_EN
      exp_fetch = 10'b10_0001_0000;
`else
      exp_fetch = 10'b00_0000_0000;
`endif
      bus.i_addr    = 32'h0000_2000;
      bus.d_we      = 1'b0;
      bus.d_size    = 2'b10;
      bus.d_addr    = 32'h0000_0300;
      bus.mem_rdata = 32'h0000_0077;
      bus.mem_ready = 1'b1;
      bus.i_req     = 1'b1;
      bus.d_req     = 1'b1;
      n_seen   = 0;
      last_cyc = 0;
      for (int cyc = 0; cyc < 100 && n_seen < 10; cyc++) begin
         tick();
         if (bus.i_ack || bus.d_ack) begin
            check($sformatf("contend/grant%0d_is_fetch", n_seen), 32'(bus.i_ack), 32'(exp_fetch[n_seen]));
            if (n_seen > 0) check($sformatf("contend/gap%0d", n_seen), 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            n_seen++;
         end
      end
      check("contend/ack_count", 32'(n_seen), 32'd10);
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
      tick();

      // Wait states: ready low for five BUSY cycles
      bus.d_req     = 1'b1;
      bus.d_we      = 1'b0;
      bus.d_size    = 2'b10;
      bus.d_addr    = 32'h0000_0500;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hBADB_AD00;
      busy = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.d_ack) break;
         if (bus.mem_req) begin
            busy++;
            check($sformatf("wait/addr_c%0d", busy), bus.mem_addr, 32'h0000_0500);
            check($sformatf("wait/be_c%0d", busy), 32'(bus.mem_be), 32'hF);
            if (busy == 6) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = 32'h0F0F_1234;
            end
         end
      end
      check("wait/busy_cycles", 32'(busy), 32'd6);
      check("wait/d_ack",       32'(bus.d_ack), 32'd1);
      check("wait/d_err",       32'(bus.d_err), 32'd0);
      check("wait/d_rdata",     bus.d_rdata, 32'h0F0F_1234);
      bus.d_req = 1'b0;
      tick();

      // Reset in the second BUSY_D cycle, then a clean fetch
      bus.d_req     = 1'b1;
      bus.d_addr    = 32'h0000_0600;
      bus.mem_ready = 1'b0;
      tick();
      tick();
      check("rstmid/pre_mem_req", 32'(bus.mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstmid/mem_req",  32'(bus.mem_req), 32'd0);
      check("rstmid/d_ack",    32'(bus.d_ack), 32'd0);
      check("rstmid/mem_be",   32'(bus.mem_be), 32'd0);
      check("rstmid/mem_addr", bus.mem_addr, 32'd0);
      check("rstmid/d_rdata",  bus.d_rdata, 32'd0);
      check("rstmid/i_rdata",  bus.i_rdata, 32'd0);
      bus.d_req     = 1'b0;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_req     = 1'b1;
      bus.i_addr    = 32'h0000_3008;
      bus.mem_rdata = 32'h1234_5678;
      tick();
      check("postrst/c1_mem_req",  32'(bus.mem_req), 32'd1);
      check("postrst/c1_mem_addr", bus.mem_addr, 32'h0000_3008);
      tick();
      check("postrst/c2_i_ack",    32'(bus.i_ack), 32'd1);
      check("postrst/c2_i_rdata",  bus.i_rdata, 32'h1234_5678);
      bus.i_req = 1'b0;
      tick();
      check("postrst/c3_i_ack",    32'(bus.i_ack), 32'd0);
      check("postrst/c3_mem_req",  32'(bus.mem_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
